// File: rtl/alu_logic_pipe_if.sv
// Valid/ready bus for the pipelined bitwise ALU: issue side (in_*) and result side (out_*).
// The master modport is the issuing side; the slave modport is the pipeline.
interface alu_logic_pipe_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned TAG_W = 5
) ();
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       in_op;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic             out_zero;
    logic [TAG_W-1:0] out_tag;

    modport master (
        output in_valid, in_op, in_a, in_b, in_tag, out_ready,
        input  in_ready, out_valid, out_result, out_zero, out_tag
    );

    modport slave (
        input  in_valid, in_op, in_a, in_b, in_tag, out_ready,
        output in_ready, out_valid, out_result, out_zero, out_tag
    );
endinterface

// File: rtl/alu_logic_pipe.sv
// Eight-function bitwise ALU feeding a STAGES-deep elastic valid/ready pipeline.
// Carries a zero flag and a passthrough tag alongside each result.
module alu_logic_pipe #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned STAGES = 2,
    parameter int unsigned TAG_W  = 5
) (
    input  logic              clk,
    input  logic              rst,
    alu_logic_pipe_if.slave   bus
);
    typedef enum logic [2:0] {
        OP_NOT  = 3'b000,
        OP_AND  = 3'b001,
        OP_OR   = 3'b010,
        OP_XOR  = 3'b011,
        OP_NOR  = 3'b100,
        OP_NAND = 3'b101,
        OP_XNOR = 3'b110,
        OP_PASS = 3'b111
    } op_e;

    logic [WIDTH-1:0] res_d;
    logic             zero_d;

    logic [STAGES-1:0] v_q;
    logic [WIDTH-1:0]  res_q  [STAGES];
    logic [STAGES-1:0] zero_q;
    logic [TAG_W-1:0]  tag_q  [STAGES];

    logic [STAGES-1:0] stage_rdy;
    logic [STAGES-1:0] v_in;
    logic [WIDTH-1:0]  res_in [STAGES];
    logic [STAGES-1:0] zero_in;
    logic [TAG_W-1:0]  tag_in [STAGES];

    // Function unit feeding stage 0
    always_comb begin
        res_d = bus.in_a;
        case (bus.in_op)
            OP_NOT:  res_d = ~bus.in_a;
            OP_AND:  res_d = bus.in_a & bus.in_b;
            OP_OR:   res_d = bus.in_a | bus.in_b;
            OP_XOR:  res_d = bus.in_a ^ bus.in_b;
            OP_NOR:  res_d = ~(bus.in_a | bus.in_b);
            OP_NAND: res_d = ~(bus.in_a & bus.in_b);
            OP_XNOR: res_d = ~(bus.in_a ^ bus.in_b);
            OP_PASS: res_d = bus.in_a;
            default: res_d = bus.in_a;
        endcase
        zero_d = (res_d == '0);
    end

    // Stage k accepts whenever some stage at or after it is empty, or the sink accepts
    for (genvar g = 0; g < int'(STAGES); g++) begin : g_stage
        assign stage_rdy[g] = bus.out_ready || !(&v_q[STAGES-1:g]);
        if (g == 0) begin : g_head
            assign v_in[g]    = bus.in_valid;
            assign res_in[g]  = res_d;
            assign zero_in[g] = zero_d;
            assign tag_in[g]  = bus.in_tag;
        end else begin : g_body
            assign v_in[g]    = v_q[g-1];
            assign res_in[g]  = res_q[g-1];
            assign zero_in[g] = zero_q[g-1];
            assign tag_in[g]  = tag_q[g-1];
        end
    end

    // Data only moves with a valid token so bubbles never disturb held outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < int'(STAGES); k++) begin
                v_q[k]    <= 1'b0;
                res_q[k]  <= '0;
                zero_q[k] <= 1'b1;
                tag_q[k]  <= '0;
            end
        end else begin
            for (int k = 0; k < int'(STAGES); k++) begin
                if (stage_rdy[k]) begin
                    v_q[k] <= v_in[k];
                    if (v_in[k]) begin
                        res_q[k]  <= res_in[k];
                        zero_q[k] <= zero_in[k];
                        tag_q[k]  <= tag_in[k];
                    end
                end
            end
        end
    end

    assign bus.in_ready   = stage_rdy[0] && !rst;
    assign bus.out_valid  = v_q[STAGES-1];
    assign bus.out_result = res_q[STAGES-1];
    assign bus.out_zero   = zero_q[STAGES-1];
    assign bus.out_tag    = tag_q[STAGES-1];

endmodule

// File: tb/tb_alu_logic_pipe.sv
// Bench for alu_logic_pipe: directed cases on a 32-bit/2-stage instance plus random
// traffic on three parameterisations checked against a truth-table scoreboard.
module tb_alu_logic_pipe;
    logic clk;
    logic rst;
    int   n_chk;
    int   n_err;

    typedef struct {
        logic [63:0] r;
        logic [4:0]  t;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    alu_logic_pipe_if #(.WIDTH(32), .TAG_W(5)) bus0 ();
    alu_logic_pipe_if #(.WIDTH(8),  .TAG_W(5)) bus1 ();
    alu_logic_pipe_if #(.WIDTH(64), .TAG_W(5)) bus2 ();

    alu_logic_pipe #(.WIDTH(32), .STAGES(2), .TAG_W(5)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
    alu_logic_pipe #(.WIDTH(8),  .STAGES(1), .TAG_W(5)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
    alu_logic_pipe #(.WIDTH(64), .STAGES(4), .TAG_W(5)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", name, obs, exp);
        end
    endtask

    function automatic logic [63:0] ref_op(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
        case (op)
            3'd0:    return ~a;
            3'd1:    return a & b;
            3'd2:    return a | b;
            3'd3:    return a ^ b;
            3'd4:    return ~(a | b);
            3'd5:    return ~(a & b);
            3'd6:    return ~(a ^ b);
            default: return a;
        endcase
    endfunction

    // One cycle on the 32-bit instance: drive after the edge, sample on the falling edge
    task automatic cyc0(input logic v, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] tg, input logic ordy);
        @(posedge clk);
        #1;
        bus0.in_valid  = v;
        bus0.in_op     = op;
        bus0.in_a      = a;
        bus0.in_b      = b;
        bus0.in_tag    = tg;
        bus0.out_ready = ordy;
        @(negedge clk);
    endtask

    task automatic wait_out0(output int lat);
        lat = 0;
        do begin
            cyc0(1'b0, 3'd0, 32'd0, 32'd0, 5'd0, 1'b1);
            lat++;
        end while (!bus0.out_valid && lat < 20);
    endtask

    task automatic score(input int d, input int w, input logic ov, input logic ordy, input logic iv,
                         input logic ird, input logic [63:0] res, input logic z, input logic [4:0] tg,
                         input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                         input logic [4:0] itg);
        exp_t        e;
        int          sz;
        logic [63:0] m;
        m  = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
        sz = (d == 0) ? q0.size() : (d == 1) ? q1.size() : q2.size();
        if (ov) begin
            chk($sformatf("rnd%0d_nonempty", d), 64'(sz != 0), 64'd1);
            if (sz != 0) begin
                case (d)
                    0:       e = q0[0];
                    1:       e = q1[0];
                    default: e = q2[0];
                endcase
                chk($sformatf("rnd%0d_result", d), res, e.r);
                chk($sformatf("rnd%0d_zero", d), 64'(z), 64'(e.r == 64'd0));
                chk($sformatf("rnd%0d_tag", d), 64'(tg), 64'(e.t));
                if (ordy) begin
                    case (d)
                        0:       void'(q0.pop_front());
                        1:       void'(q1.pop_front());
                        default: void'(q2.pop_front());
                    endcase
                end
            end
        end
        if (iv && ird) begin
            e.r = ref_op(op, a, b) & m;
            e.t = itg;
            case (d)
                0:       q0.push_back(e);
                1:       q1.push_back(e);
                default: q2.push_back(e);
            endcase
        end
    endtask

    initial begin
        logic [31:0] exp8 [8];
        int          lat;
        int          t;
        int          e;
        int          n;
        logic [63:0] ra;
        logic [63:0] rb;

        n_chk = 0;
        n_err = 0;
        exp8 = '{32'h0000FFFF, 32'hFF000000, 32'hFFFFFF00, 32'h00FFFF00,
                 32'h000000FF, 32'h00FFFFFF, 32'hFF0000FF, 32'hFFFF0000};

        rst = 1'b1;
        bus0.in_valid = 1'b0; bus0.in_op = 3'd0; bus0.in_a = '0; bus0.in_b = '0; bus0.in_tag = '0; bus0.out_ready = 1'b0;
        bus1.in_valid = 1'b0; bus1.in_op = 3'd0; bus1.in_a = '0; bus1.in_b = '0; bus1.in_tag = '0; bus1.out_ready = 1'b0;
        bus2.in_valid = 1'b0; bus2.in_op = 3'd0; bus2.in_a = '0; bus2.in_b = '0; bus2.in_tag = '0; bus2.out_ready = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_in_ready", 64'(bus0.in_ready), 64'd0);
        chk("rst_out_valid", 64'(bus0.out_valid), 64'd0);
        chk("rst_out_zero", 64'(bus0.out_zero), 64'd1);
        chk("rst_out_result", 64'(bus0.out_result), 64'd0);
        chk("rst_out_tag", 64'(bus0.out_tag), 64'd0);
        chk("rst_out_zero_w64", 64'(bus2.out_zero), 64'd1);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("idle_in_ready", 64'(bus0.in_ready), 64'd1);

        // Single NOT, latency STAGES
        cyc0(1'b1, 3'd0, 32'h0F0F_00FF, 32'd0, 5'd3, 1'b1);
        chk("single_accept", 64'(bus0.in_ready), 64'd1);
        wait_out0(lat);
        chk("single_latency", 64'(lat), 64'd2);
        chk("single_result", 64'(bus0.out_result), 64'hF0F0_FF00);
        chk("single_zero", 64'(bus0.out_zero), 64'd0);
        chk("single_tag", 64'(bus0.out_tag), 64'd3);

        // All eight ops back to back, one result per cycle
        for (int c = 0; c < 10; c++) begin
            if (c < 8) cyc0(1'b1, 3'(c), 32'hFFFF_0000, 32'hFF00_FF00, 5'(c), 1'b1);
            else       cyc0(1'b0, 3'd0, 32'd0, 32'd0, 5'd0, 1'b1);
            if (c < 8) chk($sformatf("ops_in_ready%0d", c), 64'(bus0.in_ready), 64'd1);
            if (c >= 2) begin
                chk($sformatf("ops_valid%0d", c), 64'(bus0.out_valid), 64'd1);
                chk($sformatf("ops_result%0d", c - 2), 64'(bus0.out_result), 64'(exp8[c-2]));
                chk($sformatf("ops_tag%0d", c - 2), 64'(bus0.out_tag), 64'(c - 2));
            end else begin
                chk($sformatf("ops_gap%0d", c), 64'(bus0.out_valid), 64'd0);
            end
        end

        // Zero flag
        cyc0(1'b1, 3'd1, 32'hAAAA_AAAA, 32'h5555_5555, 5'd9, 1'b1);
        wait_out0(lat);
        chk("zero_valid", 64'(bus0.out_valid), 64'd1);
        chk("zero_result", 64'(bus0.out_result), 64'd0);
        chk("zero_flag", 64'(bus0.out_zero), 64'd1);

        // Backpressure: fill with tags 1.., output holds tag 1
        t = 1;
        for (int i = 0; i < 6; i++) begin
            cyc0(1'b1, 3'd7, 32'(t), 32'd0, 5'(t), 1'b0);
            if (bus0.in_ready) t++;
            if (bus0.out_valid) begin
                chk("bp_hold_tag", 64'(bus0.out_tag), 64'd1);
                chk("bp_hold_result", 64'(bus0.out_result), 64'd1);
            end
        end
        chk("bp_accepted", 64'(t - 1), 64'd2);
        chk("bp_in_ready_low", 64'(bus0.in_ready), 64'd0);
        chk("bp_out_valid", 64'(bus0.out_valid), 64'd1);

        // Release: tags drain in order, full pipe accepts while releasing
        e = 1;
        n = 0;
        while (e <= 5 && n < 40) begin
            cyc0((t <= 5) ? 1'b1 : 1'b0, 3'd7, 32'(t), 32'd0, 5'(t), 1'b1);
            if (n == 0) chk("full_accept", 64'(bus0.in_ready), 64'd1);
            if (bus0.out_valid) begin
                chk("bp_order_tag", 64'(bus0.out_tag), 64'(e));
                chk("bp_order_result", 64'(bus0.out_result), 64'(e));
                e++;
            end
            if (t <= 5 && bus0.in_ready) t++;
            n++;
        end
        chk("bp_all_out", 64'(e), 64'd6);
        for (int i = 0; i < 3; i++) begin
            cyc0(1'b0, 3'd0, 32'd0, 32'd0, 5'd0, 1'b1);
            chk("bp_no_dup", 64'(bus0.out_valid), 64'd0);
        end

        // Asynchronous reset with two transactions in flight
        cyc0(1'b1, 3'd2, 32'd1, 32'd1, 5'd10, 1'b0);
        cyc0(1'b1, 3'd2, 32'd2, 32'd2, 5'd11, 1'b0);
        cyc0(1'b0, 3'd0, 32'd0, 32'd0, 5'd0, 1'b0);
        chk("mid_pre_valid", 64'(bus0.out_valid), 64'd1);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_valid", 64'(bus0.out_valid), 64'd0);
        chk("mid_rst_zero", 64'(bus0.out_zero), 64'd1);
        chk("mid_rst_in_ready", 64'(bus0.in_ready), 64'd0);
        bus0.in_valid = 1'b1; bus0.in_op = 3'd7; bus0.in_a = 32'd5; bus0.in_tag = 5'd20; bus0.out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_rst_hold", 64'(bus0.out_valid), 64'd0);
        rst = 1'b0;
        bus0.in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cyc0(1'b0, 3'd0, 32'd0, 32'd0, 5'd0, 1'b1);
            chk("mid_no_stale", 64'(bus0.out_valid), 64'd0);
        end
        cyc0(1'b1, 3'd2, 32'h1, 32'h2, 5'd12, 1'b1);
        wait_out0(lat);
        chk("post_rst_latency", 64'(lat), 64'd2);
        chk("post_rst_result", 64'(bus0.out_result), 64'd3);
        chk("post_rst_tag", 64'(bus0.out_tag), 64'd12);

        // WIDTH=8, STAGES=1 latency and NOT
        @(posedge clk);
        #1;
        bus1.in_valid = 1'b1; bus1.in_op = 3'd0; bus1.in_a = 8'h5A; bus1.in_tag = 5'd4; bus1.out_ready = 1'b1;
        @(negedge clk);
        chk("w8_accept", 64'(bus1.in_ready), 64'd1);
        lat = 0;
        do begin
            @(posedge clk);
            #1 bus1.in_valid = 1'b0;
            @(negedge clk);
            lat++;
        end while (!bus1.out_valid && lat < 20);
        chk("w8_latency", 64'(lat), 64'd1);
        chk("w8_result", 64'(bus1.out_result), 64'hA5);
        chk("w8_tag", 64'(bus1.out_tag), 64'd4);

        // WIDTH=64, STAGES=4 latency and XOR
        @(posedge clk);
        #1;
        bus2.in_valid = 1'b1; bus2.in_op = 3'd3; bus2.in_a = 64'h0123_4567_89AB_CDEF;
        bus2.in_b = 64'hFFFF_FFFF_0000_0000; bus2.in_tag = 5'd6; bus2.out_ready = 1'b1;
        @(negedge clk);
        chk("w64_accept", 64'(bus2.in_ready), 64'd1);
        lat = 0;
        do begin
            @(posedge clk);
            #1 bus2.in_valid = 1'b0;
            @(negedge clk);
            lat++;
        end while (!bus2.out_valid && lat < 20);
        chk("w64_latency", 64'(lat), 64'd4);
        chk("w64_result", bus2.out_result, 64'hFEDC_BA98_89AB_CDEF);
        chk("w64_tag", 64'(bus2.out_tag), 64'd6);

        // Random traffic with random backpressure on all three instances, then drain
        for (int i = 0; i < 412; i++) begin
            @(posedge clk);
            #1;
            ra = {$urandom(), $urandom()};
            rb = {$urandom(), $urandom()};
            bus0.in_valid  = (i < 400) && ($urandom_range(3) != 0);
            bus0.in_op     = 3'($urandom());
            bus0.in_a      = ra[31:0];
            bus0.in_b      = rb[31:0];
            bus0.in_tag    = 5'($urandom());
            bus0.out_ready = (i >= 400) || ($urandom_range(2) != 0);
            bus1.in_valid  = (i < 400) && ($urandom_range(3) != 0);
            bus1.in_op     = 3'($urandom());
            bus1.in_a      = ra[39:32];
            bus1.in_b      = rb[39:32];
            bus1.in_tag    = 5'($urandom());
            bus1.out_ready = (i >= 400) || ($urandom_range(2) != 0);
            bus2.in_valid  = (i < 400) && ($urandom_range(3) != 0);
            bus2.in_op     = 3'($urandom());
            bus2.in_a      = ra;
            bus2.in_b      = rb;
            bus2.in_tag    = 5'($urandom());
            bus2.out_ready = (i >= 400) || ($urandom_range(2) != 0);
            @(negedge clk);
            score(0, 32, bus0.out_valid, bus0.out_ready, bus0.in_valid, bus0.in_ready,
                  64'(bus0.out_result), bus0.out_zero, bus0.out_tag,
                  bus0.in_op, 64'(bus0.in_a), 64'(bus0.in_b), bus0.in_tag);
            score(1, 8, bus1.out_valid, bus1.out_ready, bus1.in_valid, bus1.in_ready,
                  64'(bus1.out_result), bus1.out_zero, bus1.out_tag,
                  bus1.in_op, 64'(bus1.in_a), 64'(bus1.in_b), bus1.in_tag);
            score(2, 64, bus2.out_valid, bus2.out_ready, bus2.in_valid, bus2.in_ready,
                  bus2.out_result, bus2.out_zero, bus2.out_tag,
                  bus2.in_op, bus2.in_a, bus2.in_b, bus2.in_tag);
        end
        chk("rnd0_drained", 64'(q0.size()), 64'd0);
        chk("rnd1_drained", 64'(q1.size()), 64'd0);
        chk("rnd2_drained", 64'(q2.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
